// File: rtl/mont_pkg.sv
// Shared types and constants for the word-serial Montgomery multiplier.
package mont_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    QCAL,
    INNER,
    TAIL,
    SUB_PRE,
    SUB,
    OUT
  } mont_state_t;

  localparam logic MODE_MUL  = 1'b0;
  localparam logic MODE_REDC = 1'b1;

endpackage

// File: rtl/mont_mac.sv
// Fused multiply-accumulate a*b + c*d + e + f, split into {carry, sum} at bit K.
module mont_mac
  import mont_pkg::*;
#(
  parameter int K = 128
) (
  input  logic [K-1:0] i_a,
  input  logic [K-1:0] i_b,
  input  logic [K-1:0] i_c,
  input  logic [K-1:0] i_d,
  input  logic [K-1:0] i_e,
  input  logic [K:0]   i_f,
  output logic [K:0]   o_carry,
  output logic [K-1:0] o_sum
);

  logic [2*K:0] w_ab;
  logic [2*K:0] w_cd;
  logic [2*K:0] w_full;

  // The worst case 2(W-1)^2 + (W-1) + (2W-1) stays below 2^(2K+1).
  assign w_ab   = {{(K+1){1'b0}}, i_a} * {{(K+1){1'b0}}, i_b};
  assign w_cd   = {{(K+1){1'b0}}, i_c} * {{(K+1){1'b0}}, i_d};
  assign w_full = w_ab + w_cd + {{(K+1){1'b0}}, i_e} + {{K{1'b0}}, i_f};

  assign {o_carry, o_sum} = w_full;

endmodule

// File: rtl/mont_mul_serial.sv
// Word-serial Montgomery multiplier: x*y*R^-1 mod p (or x*R^-1 in REDC mode),
// one MAC per cycle, with the final conditional subtraction done in-block.
module mont_mul_serial
  import mont_pkg::*;
#(
  parameter int K      = 128,
  parameter int N      = 32,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_mode,
  input  logic [K-1:0]      i_p1,
  output logic [ADDR_W-1:0] o_x_rd_addr,
  input  logic [K-1:0]      i_x_rd_data,
  output logic [ADDR_W-1:0] o_yp_rd_addr,
  input  logic [K-1:0]      i_y_rd_data,
  input  logic [K-1:0]      i_p_rd_data,
  output logic              o_busy,
  output logic              o_out_valid,
  output logic [ADDR_W-1:0] o_out_addr,
  output logic [K-1:0]      o_out_data,
  output logic              o_out_last,
  output logic              o_done
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N - 1);

  mont_state_t       r_state;
  logic [ADDR_W-1:0] r_i;
  logic [ADDR_W-1:0] r_j;
  logic [K:0]        r_c;
  logic [K-1:0]      r_q;
  logic [K-1:0]      r_xi;
  logic              r_mode;
  logic              r_b;
  logic              r_t_hi;
  logic              r_busy;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  logic [K-1:0]      r_out_data;
  logic              r_out_last;
  logic              r_done;

  // t[0..N-1] live in r_t, t[N] in r_t_top.
  logic [K-1:0]      r_t [0:N-1];
  logic [K-1:0]      r_t_top;
  logic [K-1:0]      r_d [0:N-1];

  logic              w_accept;
  logic              w_j_last;
  logic [K-1:0]      w_y;
  logic [K-1:0]      w_q;
  logic [K:0]        w_mac_carry;
  logic [K-1:0]      w_mac_sum;
  logic [K+1:0]      w_tail;
  logic [K:0]        w_diff;
  logic              w_sel;
  logic [ADDR_W-1:0] w_yp_addr;

  assign w_accept = (r_state == IDLE) && i_start && !r_busy;
  assign w_j_last = (r_j == LAST);

  // REDC replaces y by the constant 1; r_j is 0 during QCAL, so y0 = 1 there too.
  assign w_y = (r_mode == MODE_REDC) ? ((r_j == '0) ? K'(1) : '0) : i_y_rd_data;

  assign w_q    = (r_t[0] + i_x_rd_data * w_y) * i_p1;
  assign w_tail = {2'b00, r_t_top} + {1'b0, r_c};
  assign w_diff = {1'b0, r_t[r_j]} - {1'b0, i_p_rd_data} - {{K{1'b0}}, r_b};
  assign w_sel  = (r_t_top != '0) || !r_b;

  mont_mac #(.K(K)) u_mac (
    .i_a     (r_xi),
    .i_b     (w_y),
    .i_c     (r_q),
    .i_d     (i_p_rd_data),
    .i_e     (r_t[r_j]),
    .i_f     (r_c),
    .o_carry (w_mac_carry),
    .o_sum   (w_mac_sum)
  );

  always_comb begin
    w_yp_addr = '0;
    if ((r_state == INNER || r_state == SUB) && !w_j_last) begin
      w_yp_addr = r_j + ADDR_W'(1);
    end
  end

  assign o_x_rd_addr  = r_i;
  assign o_yp_rd_addr = w_yp_addr;
  assign o_busy       = r_busy;
  assign o_out_valid  = r_out_valid;
  assign o_out_addr   = r_out_addr;
  assign o_out_data   = r_out_data;
  assign o_out_last   = r_out_last;
  assign o_done       = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_i         <= '0;
      r_j         <= '0;
      r_c         <= '0;
      r_q         <= '0;
      r_xi        <= '0;
      r_mode      <= MODE_MUL;
      r_b         <= 1'b0;
      r_t_hi      <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_done      <= 1'b0;
      // busy covers the done cycle, so a start coinciding with done is ignored
      if (r_done) begin
        r_busy <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_mode  <= i_mode;
            r_i     <= '0;
            r_j     <= '0;
            r_c     <= '0;
            r_t_hi  <= 1'b0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: r_state <= QCAL;
        QCAL: begin
          r_q     <= w_q;
          r_xi    <= i_x_rd_data;
          r_j     <= '0;
          r_c     <= '0;
          r_state <= INNER;
        end
        INNER: begin
          r_c <= w_mac_carry;
          if (w_j_last) begin
            r_j     <= '0;
            r_state <= TAIL;
          end else begin
            r_j <= r_j + ADDR_W'(1);
          end
        end
        TAIL: begin
          if (r_i == LAST) begin
            r_i     <= '0;
            r_state <= SUB_PRE;
          end else begin
            r_i     <= r_i + ADDR_W'(1);
            r_state <= LOAD;
          end
        end
        SUB_PRE: begin
          r_b     <= 1'b0;
          r_j     <= '0;
          r_state <= SUB;
        end
        SUB: begin
          r_b <= w_diff[K];
          if (w_j_last) begin
            r_j     <= '0;
            r_state <= OUT;
          end else begin
            r_j <= r_j + ADDR_W'(1);
          end
        end
        OUT: begin
          r_out_valid <= 1'b1;
          r_out_addr  <= r_j;
          r_out_data  <= w_sel ? r_d[r_j] : r_t[r_j];
          if (w_j_last) begin
            r_out_last <= 1'b1;
            r_done     <= 1'b1;
            r_j        <= '0;
            r_state    <= IDLE;
          end else begin
            r_j <= r_j + ADDR_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Word storage carries no reset; its contents are rebuilt by every run.
  always_ff @(posedge i_clk) begin
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          for (int k = 0; k < N; k++) begin
            r_t[k] <= '0;
          end
          r_t_top <= '0;
        end
      end
      INNER: begin
        if (r_j != '0) begin
          r_t[r_j - ADDR_W'(1)] <= w_mac_sum;
        end
      end
      TAIL: begin
        r_t[LAST] <= w_tail[K-1:0];
        r_t_top   <= K'(r_t_hi) + K'(w_tail[K+1:K]);
      end
      SUB: r_d[r_j] <= w_diff[K-1:0];
      default: ;
    endcase
  end

endmodule
